fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write-port arbiter for the FIFO RAM write interface. It shares
//   the single write port (winc/wdata toward the write-pointer/full logic and
//   RAM) among NUM_REQ producers using valid/ready handshakes and honours wfull.
//   Grants are bounded bursts of up to MAX_BURST beats, for fairness.
//   Sits entirely in the write clock domain, in front of the FIFO write side.
// PARAMETERS
//   NUM_REQ   = 4  number of requesters (>=2)
//   datawidth = 8  data word width, matches the FIFO RAM
//   MAX_BURST = 4  max beats per grant before forced rotation (>=1)
// PORTS
//   wclk       in   1                  write clock; all state on posedge
//   wrst_n     in   1                  async active-low reset
//   req_valid  in   NUM_REQ            per-requester data valid
//   req_data   in   NUM_REQ*datawidth  requester i data in [i*datawidth +: datawidth]
//   req_ready  out  NUM_REQ            one-hot accept; beat transfers when valid&ready
//   wfull      in   1                  FIFO full from the write-pointer logic
//   winc       out  1                  write strobe to the pointer logic / RAM wclken
//   wdata      out  datawidth          write data to the RAM
//   grant_id   out  $clog2(NUM_REQ)    currently/last granted requester index
//   busy       out  1                  1 while state==BURST
// BEHAVIOUR
// - Reset (async, wrst_n=0): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
//   winc=0, req_ready=0, busy=0 and wdata=0 immediately; no write is issued.
// - States: IDLE, BURST.
//   - IDLE: if any req_valid, pick the first i with req_valid[i], searching
//     rr_ptr, rr_ptr+1, ... mod NUM_REQ. Register grant_id=i, burst_cnt=0 and
//     go to BURST. If none are valid, stay in IDLE. No transfer happens in IDLE.
//   - BURST: req_ready[grant_id] = req_valid[grant_id] & ~wfull; the others are 0.
//     winc = req_ready[grant_id]; wdata = slice grant_id of req_data when winc,
//     else 0 (both combinational, same cycle).
//     - Beat (winc=1): burst_cnt++. If burst_cnt==MAX_BURST-1, go to IDLE and
//       set rr_ptr=(grant_id+1)%NUM_REQ.
//     - req_valid[grant_id]==0: go to IDLE, rr_ptr=(grant_id+1)%NUM_REQ, no beat.
//     - wfull=1 with valid=1: stall. Stay in BURST, no beat, burst_cnt held,
//       grant kept.
// - Latency: one arbitration cycle (IDLE) before the first beat; one bubble
//   cycle between grants. Peak rate MAX_BURST beats per MAX_BURST+1 cycles.
// - winc is never 1 while wfull=1; at most one req_ready bit is high.
// - Requester valid and data must stay stable until ready. If valid drops
//   mid-burst, the grant is released.
// - Requests on other indices during BURST are ignored until the return to IDLE.
// - burst_cnt width is $clog2(MAX_BURST)+1; no wrap is possible.
// - rr_ptr wraps NUM_REQ-1 -> 0.
// - wrst_n asserted mid-burst: the burst is abandoned, the in-flight beat is
//   not written, and arbitration restarts at requester 0.
// TESTING
// 1. Reset: wrst_n=0 while req_valid=4'b1111 -> winc=0, req_ready=0, busy=0,
//    grant_id=0. Release -> first beat from req 0 two edges later.
// 2. Single requester: req_valid=4'b0100 held, data 8'hA0.. -> grant_id=2;
//    4 beats (A0..A3), 1 idle cycle, then 4 more. winc pattern 11110 repeating.
// 3. Round robin: all valid, MAX_BURST=4 -> grant order 0,1,2,3,0; exactly 4
//    beats each; wdata tagged by requester.
// 4. Full stall: wfull=1 during beat 2 for 3 cycles -> winc=0 and req_ready=0
//    for 3 cycles, grant held, then beats 2-3 complete. No write while full.
// 5. Early release: req 1 drops valid after 2 beats -> IDLE, next grant goes to
//    req 2 (rr_ptr=2) even though req 0 is valid.
// 6. Reset mid-burst at beat 1 of req 3 -> winc=0 at once; after release,
//    arbitration restarts at 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : fifo_wr_arbiter                                             |
// | Description: Round-robin, burst-bounded arbiter sharing the FIFO write   |
// |              port among NUM_REQ valid/ready producers; honours wfull.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int datawidth = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                           wclk,
    input  logic                           wrst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*datawidth-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           wfull,
    output logic                           winc,
    output logic [datawidth-1:0]           wdata,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    logic [0:0]         r_state,     w_state_nxt;
    logic [c_ID_W-1:0]  r_rr_ptr,    w_rr_ptr_nxt;
    logic [c_ID_W-1:0]  r_grant_id,  w_grant_id_nxt;
    logic [c_CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;

    logic [c_ID_W:0]    w_sum;
    logic [c_ID_W-1:0]  w_pick;
    logic               w_any;
    logic               w_gnt_valid;
    logic               w_beat;
    logic [c_ID_W-1:0]  w_next_ptr;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_ID_W+1)'(k);
            if (w_sum >= (c_ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_ID_W+1)'(NUM_REQ);
            end
            if (!w_any && req_valid[w_sum[c_ID_W-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[c_ID_W-1:0];
            end
        end
    end

    assign w_gnt_valid = req_valid[r_grant_id];
    assign w_beat      = (r_state == c_BURST) && w_gnt_valid && !wfull;
    assign w_next_ptr  = (r_grant_id == c_ID_W'(NUM_REQ-1)) ? '0
                                                             : r_grant_id + c_ID_W'(1);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_state_nxt     = c_BURST;
                    w_grant_id_nxt  = w_pick;
                    w_burst_cnt_nxt = '0;
                end
            end
            c_BURST: begin
                // A dropped valid releases the grant; a full stall just holds
                if (!w_gnt_valid) begin
                    w_state_nxt  = c_IDLE;
                    w_rr_ptr_nxt = w_next_ptr;
                end else if (w_beat) begin
                    w_burst_cnt_nxt = r_burst_cnt + c_CNT_W'(1);
                    if (r_burst_cnt == c_CNT_W'(MAX_BURST-1)) begin
                        w_state_nxt  = c_IDLE;
                        w_rr_ptr_nxt = w_next_ptr;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        busy      = (r_state == c_BURST);
        if (w_beat) begin
            req_ready[r_grant_id] = 1'b1;
            winc                  = 1'b1;
            wdata                 = req_data[r_grant_id*datawidth +: datawidth];
        end
    end

    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_fifo_wr_arbiter                                          |
// | Description: Scoreboard bench for fifo_wr_arbiter: directed scenarios    |
// |              followed by constrained-random valid/wfull traffic.         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic                   wclk;
    logic                   wrst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   wfull;
    logic                   winc;
    logic [DW-1:0]          wdata;
    logic [1:0]             grant_id;
    logic                   busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .datawidth (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        int        cyc;
        int        id;
        logic [7:0] data;
    } exp_t;

    exp_t           q[$];
    exp_t           mon_e;
    int             n_chk  = 0;
    int             n_fail = 0;
    int             cyc    = 0;
    bit             mon_en = 1'b0;
    logic           exp_busy = 1'b0;
    logic [1:0]     exp_gid  = 2'd0;

    logic [3:0]     v;
    logic           full;
    logic [5:0]     seq [NUM_REQ];

    // Reference model: who owns the port, beats used, where the next search starts
    bit             m_busy;
    int             m_owner;
    int             m_beats;
    int             m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
    endtask

    task automatic drive();
        req_valid = v;
        wfull     = full;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = {2'(i), seq[i]};
    endtask

    task automatic step(input bit rnd);
        bit wr;
        int wr_id;
        int pick;
        wr    = 1'b0;
        wr_id = 0;
        pick  = -1;
        drive();
        exp_busy = m_busy;
        exp_gid  = 2'(m_owner);
        if (!m_busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (pick < 0 && v[(m_ptr + k) % NUM_REQ]) pick = (m_ptr + k) % NUM_REQ;
            end
            if (pick >= 0) begin
                m_busy  = 1'b1;
                m_owner = pick;
                m_beats = 0;
            end
        end else if (v[m_owner] && !full) begin
            wr    = 1'b1;
            wr_id = m_owner;
            q.push_back('{cyc, m_owner, {2'(m_owner), seq[m_owner]}});
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NUM_REQ;
            end
        end else if (!v[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NUM_REQ;
        end
        @(posedge wclk);
        #1;
        cyc++;
        if (wr) begin
            seq[wr_id] = seq[wr_id] + 6'd1;
            if (rnd && $urandom_range(3) == 0) v[wr_id] = 1'b0;
        end
        if (rnd) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!v[i] && $urandom_range(2) == 0) v[i] = 1'b1;
            end
            full = ($urandom_range(4) == 0);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    always @(negedge wclk) begin
        if (mon_en && wrst_n) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("grant_id", 32'(grant_id), 32'(exp_gid));
            chk("no write while full", 32'(winc & wfull), 32'd0);
            chk("ready onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (winc) begin
                if (q.size() == 0) begin
                    chk("unexpected write", 32'(winc), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("write cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("wdata", 32'(wdata), 32'(mon_e.data));
                    chk("req_ready", 32'(req_ready), 32'd1 << mon_e.id);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                chk("missing write", 32'(winc), 32'd1);
                mon_e = q.pop_front();
            end
        end
    end

    initial begin
        wrst_n = 1'b0;
        v      = 4'hF;
        full   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) seq[i] = 6'd0;
        model_reset();
        drive();
        repeat (2) @(posedge wclk);
        #1;
        chk("reset winc", 32'(winc), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);
        chk("reset wdata", 32'(wdata), 32'd0);

        wrst_n = 1'b1;
        mon_en = 1'b1;
        // all valid: grants rotate 0,1,2,3,0 with four beats each
        steps(26);
        v = 4'h0; steps(2);

        // lone requester 2: 11110 winc pattern
        v = 4'b0100; steps(10);
        v = 4'h0; steps(2);

        // full stall in the middle of a burst from requester 0
        v = 4'b0001; steps(3);
        full = 1'b1; steps(3);
        full = 1'b0; steps(3);
        v = 4'h0; steps(1);

        // requester 1 drops after two beats; requester 2 is next, not 0
        v = 4'b0111; steps(3);
        v = 4'b0101; steps(7);
        v = 4'h0; steps(2);

        // reset during beat 1 of requester 3
        chk("scoreboard drained before reset", 32'(q.size()), 32'd0);
        q.delete();
        wrst_n = 1'b0;
        model_reset();
        @(posedge wclk); #1;
        wrst_n = 1'b1;
        v = 4'b1000; steps(2);
        drive();
        #1;
        chk("mid-burst winc", 32'(winc), 32'd1);
        chk("mid-burst grant", 32'(grant_id), 32'd3);
        wrst_n = 1'b0;
        #1;
        chk("async reset winc", 32'(winc), 32'd0);
        chk("async reset req_ready", 32'(req_ready), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset grant_id", 32'(grant_id), 32'd0);
        @(posedge wclk); #1;
        @(posedge wclk); #1;
        wrst_n = 1'b1;
        model_reset();
        v = 4'hF; steps(6);

        for (int i = 0; i < 600; i++) step(1'b1);

        v = 4'h0; full = 1'b0; steps(8);
        chk("scoreboard drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
